// File: rtl/argo_chan_reader.sv
// Receive-side adapter for an Argo channel FIFO: prefetches words into a 2-entry
// register buffer and offers them over valid/ready at up to one word per cycle.
module argo_chan_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int CHAN_ID    = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [31:0]           recv_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t                  occ, occ_nxt;
   logic                  inflight;
   logic                  head, tail;
   logic [DATA_WIDTH-1:0] mem [2];
   logic                  pop, push;
   logic [2:0]            level;

   assign push      = inflight;
   assign out_valid = (occ != EMPTY);
   assign out_data  = mem[head];
   assign pop       = out_valid & out_ready;

   // Entries committed after this edge; issuing keeps it below the 2-entry capacity.
   assign level      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign fifo_rd_en = rst & ~fifo_empty & (level < 3'd2);

   always_comb begin
      occ_nxt = occ;
      case (occ)
         EMPTY: if (push) occ_nxt = ONE;
         ONE: begin
            if (push && !pop)      occ_nxt = TWO;
            else if (pop && !push) occ_nxt = EMPTY;
         end
         TWO:     if (pop && !push) occ_nxt = ONE;
         default: occ_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ        <= EMPTY;
         inflight   <= 1'b0;
         head       <= 1'b0;
         tail       <= 1'b0;
         recv_count <= '0;
         mem[0]     <= '0;
         mem[1]     <= '0;
      end else begin
         occ      <= occ_nxt;
         inflight <= fifo_rd_en;
         if (push) begin
            mem[tail] <= fifo_rd_data;
            tail      <= ~tail;
         end
         if (pop) begin
            head       <= ~head;
            recv_count <= recv_count + 32'd1;
         end
      end
   end

`ifndef SYNTHESIS
   logic [31:0] cyc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cyc <= '0;
      else      cyc <= cyc + 32'd1;
   end

   // Trace and overflow guard; a push into a full buffer would overwrite the head word.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (fifo_rd_en)
            $display("[%0d] chan %0d issue", cyc, CHAN_ID);
         if (pop)
            $display("[%0d] chan %0d pop data=%h", cyc, CHAN_ID, out_data);
         if (push && !pop && occ == TWO)
            $display("[%0d] chan %0d buffer overflow", cyc, CHAN_ID);
         assert (!(push && !pop && occ == TWO))
            else $error("argo_chan_reader chan %0d overflow", CHAN_ID);
      end
   end
`endif

endmodule

// File: tb/tb_argo_chan_reader.sv
// Bench for argo_chan_reader: queue-based FIFO and buffer model, per-cycle compare,
// directed scenarios plus randomized valid/ready traffic.
module tb_argo_chan_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [31:0] fifo_rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [31:0] recv_count;

   always #5 clk = ~clk;

   argo_chan_reader #(.DATA_WIDTH(32), .CHAN_ID(7)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .recv_count   (recv_count)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] fq[$];      // words still in the channel FIFO
   logic [31:0] bq[$];      // words held in the reader buffer, head first
   logic [31:0] got[$];     // words handed to the consumer
   bit          pend;       // a FIFO read is in flight
   logic [31:0] pend_w;
   logic [31:0] recv_m;
   logic [31:0] seqw;
   int          rd_pulses;
   int          popcnt;
   bit          last_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_check();
      bit pop_m;
      int lvl;
      pop_m = (bq.size() > 0) && out_ready;
      lvl   = bq.size() + int'(pend) - int'(pop_m);
      chk("out_valid", out_valid, (bq.size() > 0) ? 32'd1 : 32'd0);
      if (bq.size() > 0) chk("out_data", out_data, bq[0]);
      if (!rst) chk("rst_out_data", out_data, 32'd0);
      chk("recv_count", recv_count, recv_m);
      chk("fifo_rd_en", fifo_rd_en, (rst && fq.size() > 0 && lvl < 2) ? 32'd1 : 32'd0);
   endtask

   // One clock cycle, entered and left at a negative edge.
   task automatic cycle(input bit rdy, input int nload);
      bit          rd, pop;
      logic [31:0] od;
      for (int i = 0; i < nload; i++) begin
         fq.push_back(seqw);
         seqw = seqw + 32'd1;
      end
      fifo_empty = (fq.size() == 0);
      out_ready  = rdy;
      #1;
      model_check();
      rd         = fifo_rd_en;
      pop        = out_valid && out_ready;
      od         = out_data;
      last_valid = out_valid;
      if (rd) rd_pulses++;
      @(posedge clk);
      #1;
      if (pop) begin
         if (bq.size() > 0) void'(bq.pop_front());
         got.push_back(od);
         recv_m = recv_m + 32'd1;
         popcnt++;
      end
      if (pend) bq.push_back(pend_w);
      pend = rd;
      if (rd) begin
         pend_w       = (fq.size() > 0) ? fq.pop_front() : 32'hDEAD_BEEF;
         fifo_rd_data = pend_w;
      end else begin
         fifo_rd_data = $urandom;
      end
      fifo_empty = (fq.size() == 0);
      @(negedge clk);
   endtask

   task automatic assert_reset();
      rst = 1'b0;
      #1;
      chk("rst_valid", out_valid, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_count", recv_count, 32'd0);
      chk("rst_rd_en", fifo_rd_en, 32'd0);
      bq.delete();
      pend   = 1'b0;
      recv_m = '0;
   endtask

   initial begin
      int          n, loaded, nl, p0, vcnt;
      logic [31:0] base;
      rst          = 1'b0;
      out_ready    = 1'b0;
      fifo_empty   = 1'b1;
      fifo_rd_data = '0;
      seqw         = 32'hA000_0000;
      pend         = 1'b0;
      pend_w       = '0;
      recv_m       = '0;
      rd_pulses    = 0;
      popcnt       = 0;
      last_valid   = 1'b0;

      // Reset with three words waiting, then release and collect them in order.
      @(negedge clk);
      assert_reset();
      @(negedge clk);
      cycle(1'b1, 3);
      cycle(1'b1, 0);
      cycle(1'b1, 0);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) cycle(1'b1, 0);
      chk("t1_count", got.size(), 32'd3);
      if (got.size() == 3) begin
         chk("t1_word_a", got[0], 32'hA000_0000);
         chk("t1_word_b", got[1], 32'hA000_0001);
         chk("t1_word_c", got[2], 32'hA000_0002);
      end

      // Full-throughput streaming of eight words.
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, (i == 0) ? 8 : 0);
         if (last_valid) vcnt++;
      end
      chk("t2_valid_cycles", vcnt, 32'd8);
      chk("t2_recv", recv_count, 32'd11);

      // Stalled consumer: buffer fills with exactly two reads, then drains.
      base      = seqw;
      rd_pulses = 0;
      for (int i = 0; i < 6; i++) cycle(1'b0, (i == 0) ? 5 : 0);
      chk("t3_pulses", rd_pulses, 32'd2);
      chk("t3_valid", out_valid, 32'd1);
      chk("t3_head", out_data, base);
      for (int i = 0; i < 10; i++) cycle(1'b1, 0);
      chk("t3_recv", recv_count, 32'd16);

      // Single word.
      rd_pulses = 0;
      cycle(1'b1, 1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 0);
      chk("t4_pulses", rd_pulses, 32'd1);
      chk("t4_valid", out_valid, 32'd0);
      chk("t4_rd_en", fifo_rd_en, 32'd0);
      chk("t4_recv", recv_count, 32'd17);

      // Reset with a buffered word and a read in flight; both are dropped.
      cycle(1'b0, 5);
      cycle(1'b0, 0);
      assert_reset();
      @(negedge clk);
      cycle(1'b1, 0);
      cycle(1'b1, 0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) cycle(1'b1, 0);
      chk("t5_recv", recv_count, 32'd3);
      chk("t5_last_word", got[got.size()-1], seqw - 32'd1);

      // Delivery counter wrap from a forced starting value.
      force dut.recv_count = 32'hFFFF_FFFE;
      #2;
      release dut.recv_count;
      recv_m = 32'hFFFF_FFFE;
      p0 = popcnt;
      n  = 0;
      while ((popcnt - p0) < 2 && n < 20) begin
         cycle(1'b1, (n == 0) ? 3 : 0);
         n++;
      end
      chk("t6_wrap0", recv_count, 32'd0);
      n = 0;
      while ((popcnt - p0) < 3 && n < 20) begin
         cycle(1'b1, 0);
         n++;
      end
      chk("t6_wrap1", recv_count, 32'd1);

      // Random producer fill and consumer back-pressure over 1000 words.
      loaded = 0;
      p0     = popcnt;
      n      = 0;
      while ((popcnt - p0) < 1000 && n < 20000) begin
         nl = 0;
         if (loaded < 1000 && $urandom_range(0, 2) != 0) begin
            nl = $urandom_range(1, 2);
            if (nl > 1000 - loaded) nl = 1000 - loaded;
         end
         loaded += nl;
         cycle($urandom_range(0, 3) != 0, nl);
         n++;
      end
      chk("rand_delivered", popcnt - p0, 32'd1000);
      for (int i = 0; i < 4; i++) cycle(1'b1, 0);
      chk("rand_fifo_drained", fq.size(), 32'd0);
      chk("rand_buf_drained", out_valid, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
